// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared widths, state encodings and byte helpers for mem_ctrl
package mem_ctrl_pkg;

  localparam int          ADDR_WID         = 32;
  localparam int          DEF_IF_BLK_BYTES = 64;
  localparam logic [31:0] DEF_IO_BASE      = 32'h30000;

  // lsb_len carries (bytes - 1): 0 = byte, 1 = half, 3 = word
  typedef logic [1:0] lsb_len_t;

  localparam logic [2:0] MC_IDLE     = 3'd0;
  localparam logic [2:0] MC_IF_READ  = 3'd1;
  localparam logic [2:0] MC_LS_READ  = 3'd2;
  localparam logic [2:0] MC_LS_WRITE = 3'd3;
  localparam logic [2:0] MC_COOL     = 3'd4;

  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - fetch, load/store and byte-wide RAM/IO port bundle for mem_ctrl
interface mem_ctrl_if
  import mem_ctrl_pkg::*;
#(
  parameter int BLK_BYTES = DEF_IF_BLK_BYTES
) ();

  logic                   if_en;
  logic [ADDR_WID-1:0]    if_pc;
  logic                   if_done;
  logic [BLK_BYTES*8-1:0] if_data;

  logic                   lsb_en;
  logic                   lsb_wr;
  logic [ADDR_WID-1:0]    lsb_addr;
  lsb_len_t               lsb_len;
  logic [31:0]            lsb_w_data;
  logic                   lsb_done;
  logic [31:0]            lsb_r_data;

  logic [7:0]             mem_din;
  logic [7:0]             mem_dout;
  logic [ADDR_WID-1:0]    mem_a;
  logic                   mem_wr;
  logic                   io_buffer_full;

  modport slave (
    input  if_en, if_pc, lsb_en, lsb_wr, lsb_addr, lsb_len, lsb_w_data,
    input  mem_din, io_buffer_full,
    output if_done, if_data, lsb_done, lsb_r_data,
    output mem_dout, mem_a, mem_wr
  );

  modport master (
    output if_en, if_pc, lsb_en, lsb_wr, lsb_addr, lsb_len, lsb_w_data,
    output mem_din, io_buffer_full,
    input  if_done, if_data, lsb_done, lsb_r_data,
    input  mem_dout, mem_a, mem_wr
  );

endinterface

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial RAM/IO sequencer serving block fetches and LSB loads/stores
// Optional MC_IO_STALL_EN: hold IO-space store bytes while io_buffer_full is high.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int                  IF_BLK_BYTES = DEF_IF_BLK_BYTES,
  parameter logic [ADDR_WID-1:0] IO_BASE      = DEF_IO_BASE
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rdy,
  input  logic      rob_clear,
  mem_ctrl_if.slave bus
);

  localparam int                  CNT_W    = $clog2(IF_BLK_BYTES + 1);
  localparam int                  BLK_W    = IF_BLK_BYTES * 8;
  localparam logic [CNT_W-1:0]    IF_LAST  = CNT_W'(IF_BLK_BYTES - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_WID-1:0] ADDR_ONE = ADDR_WID'(1);

  logic [2:0]          state_q, state_d;
  logic [ADDR_WID-1:0] mem_a_q, mem_a_d;
  logic [7:0]          mem_dout_q, mem_dout_d;
  logic                mem_wr_q, mem_wr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    last_q, last_d;
  logic [CNT_W-1:0]    rx_idx;
  logic [31:0]         w_data_q, w_data_d;
  logic [BLK_W-1:0]    if_buf_q, if_buf_d;
  logic [BLK_W-1:0]    if_data_q, if_data_d;
  logic                if_done_q, if_done_d;
  logic [31:0]         ld_buf_q, ld_buf_d;
  logic [31:0]         lsb_r_data_q, lsb_r_data_d;
  logic                lsb_done_q, lsb_done_d;
  logic                stall;

`ifdef MC_IO_STALL_EN
  assign stall = (state_q == MC_LS_WRITE) && bus.io_buffer_full && (mem_a_q >= IO_BASE);
`else
  logic unused_io;
  assign unused_io = ^{bus.io_buffer_full, IO_BASE};
  assign stall     = 1'b0;
`endif

  // cnt_q counts edges spent in a read state; the byte arriving now was addressed cnt_q-1 edges ago
  assign rx_idx = cnt_q - CNT_ONE;

  always_comb begin
    state_d      = state_q;
    mem_a_d      = mem_a_q;
    mem_dout_d   = mem_dout_q;
    mem_wr_d     = mem_wr_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    w_data_d     = w_data_q;
    if_buf_d     = if_buf_q;
    if_data_d    = if_data_q;
    ld_buf_d     = ld_buf_q;
    lsb_r_data_d = lsb_r_data_q;
    if_done_d    = 1'b0;
    lsb_done_d   = 1'b0;

    case (state_q)
      MC_IDLE: begin
        // A flushed load is dropped here; stores survive rob_clear
        if (bus.lsb_en && (bus.lsb_wr || !rob_clear)) begin
          mem_a_d  = bus.lsb_addr;
          cnt_d    = '0;
          last_d   = CNT_W'(bus.lsb_len);
          w_data_d = bus.lsb_w_data;
          ld_buf_d = '0;
          if (bus.lsb_wr) begin
            state_d    = MC_LS_WRITE;
            mem_wr_d   = 1'b1;
            mem_dout_d = bus.lsb_w_data[7:0];
          end else begin
            state_d  = MC_LS_READ;
            mem_wr_d = 1'b0;
          end
        end else if (bus.if_en) begin
          state_d  = MC_IF_READ;
          mem_a_d  = bus.if_pc;
          cnt_d    = '0;
          last_d   = IF_LAST;
          mem_wr_d = 1'b0;
        end
      end

      MC_IF_READ: begin
        if (!bus.if_en) begin
          state_d = MC_IDLE;
          mem_a_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q < last_q) mem_a_d = mem_a_q + ADDR_ONE;
          if (cnt_q != '0) begin
            if_buf_d[{rx_idx, 3'b000} +: 8] = bus.mem_din;
            if (rx_idx == last_q) begin
              if_data_d = if_buf_d;
              if_done_d = 1'b1;
              state_d   = MC_COOL;
              mem_a_d   = '0;
            end
          end
        end
      end

      MC_LS_READ: begin
        if (rob_clear) begin
          state_d = MC_IDLE;
          mem_a_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q < last_q) mem_a_d = mem_a_q + ADDR_ONE;
          if (cnt_q != '0) begin
            ld_buf_d[{rx_idx[1:0], 3'b000} +: 8] = bus.mem_din;
            if (rx_idx == last_q) begin
              lsb_r_data_d = ld_buf_d;
              lsb_done_d   = 1'b1;
              state_d      = MC_COOL;
              mem_a_d      = '0;
            end
          end
        end
      end

      MC_LS_WRITE: begin
        if (!stall) begin
          if (cnt_q == last_q) begin
            lsb_done_d = 1'b1;
            mem_wr_d   = 1'b0;
            mem_dout_d = '0;
            mem_a_d    = '0;
            state_d    = MC_COOL;
          end else begin
            cnt_d      = cnt_q + CNT_ONE;
            mem_a_d    = mem_a_q + ADDR_ONE;
            mem_dout_d = byte_sel(w_data_q, cnt_q[1:0] + 2'd1);
          end
        end
      end

      // Requesters drop en only after seeing done, so this cycle must not re-arbitrate
      MC_COOL: state_d = MC_IDLE;

      default: state_d = MC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= MC_IDLE;
      mem_a_q      <= '0;
      mem_dout_q   <= '0;
      mem_wr_q     <= 1'b0;
      cnt_q        <= '0;
      last_q       <= '0;
      w_data_q     <= '0;
      if_buf_q     <= '0;
      if_data_q    <= '0;
      if_done_q    <= 1'b0;
      ld_buf_q     <= '0;
      lsb_r_data_q <= '0;
      lsb_done_q   <= 1'b0;
    end else if (rdy) begin
      state_q      <= state_d;
      mem_a_q      <= mem_a_d;
      mem_dout_q   <= mem_dout_d;
      mem_wr_q     <= mem_wr_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      w_data_q     <= w_data_d;
      if_buf_q     <= if_buf_d;
      if_data_q    <= if_data_d;
      if_done_q    <= if_done_d;
      ld_buf_q     <= ld_buf_d;
      lsb_r_data_q <= lsb_r_data_d;
      lsb_done_q   <= lsb_done_d;
    end
  end

  assign bus.mem_a      = mem_a_q;
  assign bus.mem_dout   = mem_dout_q;
  assign bus.mem_wr     = mem_wr_q & rdy & ~stall;
  assign bus.if_done    = if_done_q;
  assign bus.if_data    = if_data_q;
  assign bus.lsb_done   = lsb_done_q;
  assign bus.lsb_r_data = lsb_r_data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed self-checking bench for mem_ctrl
module tb_mem_ctrl;

  localparam int BLK = 64;

  logic clk = 1'b0;
  logic rst, rdy, rob_clear;

  mem_ctrl_if #(.BLK_BYTES(BLK)) bus ();

  mem_ctrl #(.IF_BLK_BYTES(BLK), .IO_BASE(32'h30000)) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .rob_clear (rob_clear),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  ram [0:65535];
  logic [31:0] wa_q[$];
  logic [7:0]  wd_q[$];
  int checks = 0;
  int passes = 0;

  always @(posedge clk) begin
    if (rdy) bus.mem_din <= ram[bus.mem_a[15:0]];
    if (bus.mem_wr) begin
      wa_q.push_back(bus.mem_a);
      wd_q.push_back(bus.mem_dout);
      if (bus.mem_a < 32'h10000) ram[bus.mem_a[15:0]] = bus.mem_dout;
    end
  end

  task automatic start_lsb(input logic wr, input logic [31:0] addr, input logic [1:0] len,
                           input logic [31:0] wdata);
    @(negedge clk);
    bus.lsb_wr     = wr;
    bus.lsb_addr   = addr;
    bus.lsb_len    = len;
    bus.lsb_w_data = wdata;
    bus.lsb_en     = 1'b1;
  endtask

  task automatic start_if(input logic [31:0] pc);
    @(negedge clk);
    bus.if_pc = pc;
    bus.if_en = 1'b1;
  endtask

  // Counts cycles until done; the requester drops en just after the edge that ends the done cycle
  task automatic wait_done(input bit is_if, input int limit, output int at);
    at = -1;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      if (is_if ? bus.if_done : bus.lsb_done) begin
        at = n;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (is_if) bus.if_en = 1'b0;
    else bus.lsb_en = 1'b0;
  endtask

  function automatic logic [BLK*8-1:0] blk_pattern(input logic [7:0] base);
    logic [BLK*8-1:0] v;
    for (int i = 0; i < BLK; i++) v[8*i +: 8] = base + 8'(i);
    return v;
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (bus.mem_a !== 32'h0) $display("FAIL reset_mem_a: got %h expected 0", bus.mem_a); else passes++;
    checks++; if (bus.mem_wr !== 1'b0) $display("FAIL reset_mem_wr: got %b expected 0", bus.mem_wr); else passes++;
    checks++; if (bus.mem_dout !== 8'h0) $display("FAIL reset_mem_dout: got %h expected 0", bus.mem_dout); else passes++;
    checks++; if (bus.if_done !== 1'b0) $display("FAIL reset_if_done: got %b expected 0", bus.if_done); else passes++;
    checks++; if (bus.lsb_done !== 1'b0) $display("FAIL reset_lsb_done: got %b expected 0", bus.lsb_done); else passes++;
    checks++; if (bus.if_data !== '0) $display("FAIL reset_if_data: got nonzero expected 0"); else passes++;
    checks++; if (bus.lsb_r_data !== 32'h0) $display("FAIL reset_lsb_r_data: got %h expected 0", bus.lsb_r_data); else passes++;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.mem_a !== 32'h0 || bus.mem_wr !== 1'b0) $display("FAIL idle_after_reset: got a=%h wr=%b expected 0/0", bus.mem_a, bus.mem_wr); else passes++;
  endtask

  task automatic test_fetch();
    int at;
    start_if(32'h1000);
    wait_done(1'b1, 100, at);
    checks++; if (at !== 66) $display("FAIL fetch_done_cycle: got %0d expected 66", at); else passes++;
    checks++; if (bus.if_data !== blk_pattern(8'h00)) $display("FAIL fetch_data: got %h expected %h", bus.if_data[63:0], blk_pattern(8'h00) >> 0); else passes++;
    @(negedge clk);
    checks++; if (bus.if_done !== 1'b0 || bus.mem_a !== 32'h0) $display("FAIL fetch_cool_no_restart: got done=%b a=%h expected 0/0", bus.if_done, bus.mem_a); else passes++;
  endtask

  task automatic test_loads();
    int at;
    start_lsb(1'b0, 32'h20, 2'd3, 32'h0);
    wait_done(1'b0, 20, at);
    checks++; if (at !== 6) $display("FAIL load_word_cycle: got %0d expected 6", at); else passes++;
    checks++; if (bus.lsb_r_data !== 32'h11223344) $display("FAIL load_word_data: got %h expected 11223344", bus.lsb_r_data); else passes++;
    start_lsb(1'b0, 32'h21, 2'd0, 32'h0);
    wait_done(1'b0, 20, at);
    checks++; if (at !== 3) $display("FAIL load_byte_cycle: got %0d expected 3", at); else passes++;
    checks++; if (bus.lsb_r_data !== 32'h00000033) $display("FAIL load_byte_data: got %h expected 00000033", bus.lsb_r_data); else passes++;
    start_lsb(1'b0, 32'h22, 2'd1, 32'h0);
    wait_done(1'b0, 20, at);
    checks++; if (at !== 4) $display("FAIL load_half_cycle: got %0d expected 4", at); else passes++;
    checks++; if (bus.lsb_r_data !== 32'h00001122) $display("FAIL load_half_data: got %h expected 00001122", bus.lsb_r_data); else passes++;
  endtask

  task automatic test_stores();
    int at;
    logic [79:0] log_v;
    wa_q.delete(); wd_q.delete();
    start_lsb(1'b1, 32'h40, 2'd1, 32'h0000ABCD);
    wait_done(1'b0, 20, at);
    checks++; if (at !== 3) $display("FAIL store_half_cycle: got %0d expected 3", at); else passes++;
    log_v = (wa_q.size() == 2) ? {wa_q[0], wd_q[0], wa_q[1], wd_q[1]} : '0;
    checks++; if (log_v !== {32'h40, 8'hCD, 32'h41, 8'hAB}) $display("FAIL store_half_bytes: got n=%0d %h expected 2 writes", wa_q.size(), log_v); else passes++;

    start_lsb(1'b1, 32'h50, 2'd3, 32'hDEADBEEF);
    wait_done(1'b0, 20, at);
    checks++; if (at !== 5) $display("FAIL store_word_cycle: got %0d expected 5", at); else passes++;
    checks++; if ({ram[16'h53], ram[16'h52], ram[16'h51], ram[16'h50]} !== 32'hDEADBEEF) $display("FAIL store_word_ram: got %h%h%h%h expected deadbeef", ram[16'h53], ram[16'h52], ram[16'h51], ram[16'h50]); else passes++;

    wa_q.delete(); wd_q.delete();
    start_lsb(1'b1, 32'hFFFFFFFF, 2'd1, 32'h00001234);
    wait_done(1'b0, 20, at);
    log_v = (wa_q.size() == 2) ? {wa_q[0], wd_q[0], wa_q[1], wd_q[1]} : '0;
    checks++; if (log_v !== {32'hFFFFFFFF, 8'h34, 32'h0, 8'h12}) $display("FAIL store_addr_wrap: got n=%0d %h expected 2 writes", wa_q.size(), log_v); else passes++;

    start_lsb(1'b1, 32'h60, 2'd0, 32'h0000005A);
    rob_clear = 1'b1;
    wait_done(1'b0, 20, at);
    rob_clear = 1'b0;
    checks++; if (at !== 2 || ram[16'h60] !== 8'h5A) $display("FAIL store_ignores_rob_clear: got cycle=%0d byte=%h expected 2/5a", at, ram[16'h60]); else passes++;
  endtask

  task automatic test_arbitration();
    int at_l, at_i;
    @(negedge clk);
    bus.if_pc      = 32'h1000;
    bus.if_en      = 1'b1;
    bus.lsb_wr     = 1'b0;
    bus.lsb_addr   = 32'h20;
    bus.lsb_len    = 2'd3;
    bus.lsb_en     = 1'b1;
    wait_done(1'b0, 20, at_l);
    checks++; if (at_l !== 6 || bus.lsb_r_data !== 32'h11223344) $display("FAIL arb_load_first: got cycle=%0d data=%h expected 6/11223344", at_l, bus.lsb_r_data); else passes++;
    wait_done(1'b1, 100, at_i);
    checks++; if (at_i !== 67) $display("FAIL arb_fetch_after: got %0d expected 67", at_i); else passes++;
  endtask

  task automatic test_abort();
    int ndone;
    logic [31:0] a20, a21;
    ndone = 0; a20 = '0; a21 = '0;
    start_if(32'h1040);
    for (int n = 1; n <= 90; n++) begin
      @(negedge clk);
      if (bus.if_done) ndone++;
      if (n == 20) begin a20 = bus.mem_a; bus.if_en = 1'b0; end
      if (n == 21) a21 = bus.mem_a;
    end
    checks++; if (a20 !== 32'h1053) $display("FAIL abort_if_midfetch: got %h expected 00001053", a20); else passes++;
    checks++; if (ndone !== 0 || a21 !== 32'h0) $display("FAIL abort_if_idle: got done=%0d a=%h expected 0/0", ndone, a21); else passes++;
    checks++; if (bus.if_data !== blk_pattern(8'h00)) $display("FAIL abort_if_data_kept: got %h expected block 1000", bus.if_data[63:0]); else passes++;

    start_lsb(1'b0, 32'h20, 2'd3, 32'h0);
    repeat (2) @(negedge clk);
    @(negedge clk);
    rob_clear = 1'b1;
    @(posedge clk); #1;
    rob_clear = 1'b0;
    bus.lsb_en = 1'b0;
    ndone = 0;
    repeat (15) begin @(negedge clk); if (bus.lsb_done) ndone++; end
    checks++; if (ndone !== 0) $display("FAIL abort_load: got %0d done pulses expected 0", ndone); else passes++;

    start_lsb(1'b0, 32'h21, 2'd0, 32'h0);
    rob_clear = 1'b1;
    @(posedge clk); #1;
    rob_clear = 1'b0;
    bus.lsb_en = 1'b0;
    ndone = 0;
    repeat (10) begin @(negedge clk); if (bus.lsb_done) ndone++; end
    checks++; if (ndone !== 0 || bus.lsb_r_data !== 32'h11223344) $display("FAIL idle_rob_clear_load: got done=%0d data=%h expected 0/11223344", ndone, bus.lsb_r_data); else passes++;
  endtask

  task automatic test_rdy();
    int at;
    logic held;
    at = -1;
    start_lsb(1'b0, 32'h20, 2'd3, 32'h0);
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (bus.lsb_done) begin at = n; break; end
      if (n == 2) rdy = 1'b0;
      if (n == 5) rdy = 1'b1;
    end
    checks++; if (at !== 9) $display("FAIL rdy_freeze_latency: got %0d expected 9", at); else passes++;
    rdy = 1'b0;
    @(negedge clk);
    held = bus.lsb_done;
    rdy = 1'b1;
    @(posedge clk); #1;
    bus.lsb_en = 1'b0;
    @(negedge clk);
    checks++; if (held !== 1'b1 || bus.lsb_done !== 1'b0) $display("FAIL rdy_done_hold: got held=%b after=%b expected 1/0", held, bus.lsb_done); else passes++;

    wa_q.delete(); wd_q.delete();
    start_lsb(1'b1, 32'h70, 2'd0, 32'h00000077);
    @(negedge clk);
    checks++; if (bus.mem_wr !== 1'b1) $display("FAIL store_wr_high: got %b expected 1", bus.mem_wr); else passes++;
    rdy = 1'b0;
    #1;
    checks++; if (bus.mem_wr !== 1'b0) $display("FAIL rdy_forces_wr_low: got %b expected 0", bus.mem_wr); else passes++;
    rdy = 1'b1;
    wait_done(1'b0, 20, at);
    checks++; if (wa_q.size() !== 1 || ram[16'h70] !== 8'h77) $display("FAIL rdy_store_once: got n=%0d byte=%h expected 1/77", wa_q.size(), ram[16'h70]); else passes++;
  endtask

  task automatic test_io_stall();
    int at;
    int bad;
    logic [39:0] log_v;
    wa_q.delete(); wd_q.delete();
`ifdef MC_IO_STALL_EN
    bad = 0;
    start_lsb(1'b1, 32'h30000, 2'd0, 32'h000000A5);
    bus.io_buffer_full = 1'b1;
    repeat (3) begin @(negedge clk); if (bus.mem_wr !== 1'b0 || bus.lsb_done) bad++; end
    @(posedge clk); #1;
    bus.io_buffer_full = 1'b0;
    @(negedge clk);
    checks++; if (bad !== 0 || bus.mem_wr !== 1'b1) $display("FAIL io_stall_wr: got stalled_bad=%0d wr=%b expected 0/1", bad, bus.mem_wr); else passes++;
    @(negedge clk);
    checks++; if (bus.lsb_done !== 1'b1) $display("FAIL io_stall_done_cycle5: got %b expected 1", bus.lsb_done); else passes++;
    @(posedge clk); #1;
    bus.lsb_en = 1'b0;
`else
    bad = 0;
    start_lsb(1'b1, 32'h30000, 2'd0, 32'h000000A5);
    bus.io_buffer_full = 1'b1;
    wait_done(1'b0, 20, at);
    bus.io_buffer_full = 1'b0;
    checks++; if (at !== 2 || bad !== 0) $display("FAIL io_full_ignored: got %0d expected 2", at); else passes++;
`endif
    log_v = (wa_q.size() == 1) ? {wa_q[0], wd_q[0]} : '0;
    checks++; if (log_v !== {32'h30000, 8'hA5}) $display("FAIL io_single_write: got n=%0d %h expected one write 30000/a5", wa_q.size(), log_v); else passes++;
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) ram[a] = 8'(a);
    ram[16'h20] = 8'h44; ram[16'h21] = 8'h33; ram[16'h22] = 8'h22; ram[16'h23] = 8'h11;
    rst = 1'b1; rdy = 1'b1; rob_clear = 1'b0;
    bus.if_en = 1'b0; bus.if_pc = '0;
    bus.lsb_en = 1'b0; bus.lsb_wr = 1'b0; bus.lsb_addr = '0; bus.lsb_len = '0; bus.lsb_w_data = '0;
    bus.io_buffer_full = 1'b0;
    test_reset();
    test_fetch();
    test_loads();
    test_stores();
    test_arbitration();
    test_abort();
    test_rdy();
    test_io_stall();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
